// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP,
        LOAD
    } rx_state_t;

    localparam logic [13:0] DEF_BIT_PERIOD = 14'd10;
    localparam logic [13:0] MIN_BIT_PERIOD = 14'd4;
    localparam logic [3:0]  DEF_DATA_SIZE  = 4'd8;

    // Frame lengths outside 5..8 data bits fall back to 8.
    function automatic logic [3:0] eff_data_size(input logic [3:0] ds);
        return (ds >= 4'd5 && ds <= 4'd8) ? ds : DEF_DATA_SIZE;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit timer: counts from 1 while enabled and strobes when it reaches rollover.
module uart_bit_timer #(
    parameter int unsigned CNT_BITS = 14
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                enable,
    input  logic [CNT_BITS-1:0] rollover,
    output logic                sample_c
);

    logic [CNT_BITS-1:0] cnt_q;

    assign sample_c = enable && !clear && (cnt_q == rollover);

    // Reload to 1 on clear and on every sample so the next strobe is rollover cycles later.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= CNT_BITS'(1);
        end else if (clear || sample_c) begin
            cnt_q <= CNT_BITS'(1);
        end else if (enable) begin
            cnt_q <= cnt_q + CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: synchronizes serial_in, frames 5..8 data bits LSB-first
// and reports data/overrun/framing status to the register slave.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CNT_BITS = 14,
    parameter int unsigned MAX_DATA = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                serial_in,
    input  logic [CNT_BITS-1:0] bit_period,
    input  logic [3:0]          data_size,
    input  logic                data_read,
    output logic [MAX_DATA-1:0] rx_data,
    output logic                data_ready,
    output logic                overrun_error,
    output logic                framing_error
);

    rx_state_t           state_q, state_d;
    logic                sync1_q, sync2_q, sync3_q;
    logic                rx_s, start_c, sample_c, timer_en_c;
    logic [CNT_BITS-1:0] period_q, rollover_c;
    logic [3:0]          size_q, bit_cnt_q;
    logic [MAX_DATA-1:0] shreg_q;
    logic                stop_q;

    // Two-flop synchronizer plus one flop of history for falling-edge detect.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rx_s       = sync2_q;
    assign start_c    = (state_q == IDLE) && sync3_q && !sync2_q;
    assign timer_en_c = (state_q == START_CHK) || (state_q == DATA) || (state_q == STOP);
    assign rollover_c = (state_q == START_CHK) ? (period_q >> 1) : period_q;

    uart_bit_timer #(.CNT_BITS(CNT_BITS)) u_bit_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (start_c),
        .enable   (timer_en_c),
        .rollover (rollover_c),
        .sample_c (sample_c)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_c)  state_d = START_CHK;
            START_CHK: if (sample_c) state_d = rx_s ? IDLE : DATA;
            DATA:      if (sample_c && (bit_cnt_q == size_q - 4'd1)) state_d = STOP;
            STOP:      if (sample_c) state_d = LOAD;
            LOAD:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Frame datapath: configuration latched at start, bits enter at position N-1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            period_q  <= CNT_BITS'(MIN_BIT_PERIOD);
            size_q    <= DEF_DATA_SIZE;
            bit_cnt_q <= 4'd0;
            shreg_q   <= '0;
            stop_q    <= 1'b0;
        end else if (start_c) begin
            period_q  <= (bit_period < CNT_BITS'(MIN_BIT_PERIOD)) ? CNT_BITS'(MIN_BIT_PERIOD)
                                                                  : bit_period;
            size_q    <= eff_data_size(data_size);
            bit_cnt_q <= 4'd0;
            shreg_q   <= '0;
        end else if (sample_c && state_q == DATA) begin
            shreg_q   <= (shreg_q >> 1) | (MAX_DATA'(rx_s) << (size_q - 4'd1));
            bit_cnt_q <= bit_cnt_q + 4'd1;
        end else if (sample_c && state_q == STOP) begin
            stop_q    <= rx_s;
        end
    end

    // Status outputs; a completed frame takes priority over a coincident read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data       <= '0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else if (state_q == LOAD && stop_q) begin
            rx_data       <= shreg_q;
            data_ready    <= 1'b1;
            framing_error <= 1'b0;
            overrun_error <= !data_read && (overrun_error || data_ready);
        end else begin
            if (state_q == LOAD) begin
                framing_error <= 1'b1;
            end else if (start_c) begin
                framing_error <= 1'b0;
            end
            if (data_read && data_ready) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end

endmodule
